vga_fb_arbiter: RTL
===================

# vga_fb_arbiter

Arbiter and sequencer for a single-port framebuffer RAM shared between the VGA scan-out path and a host write port. During each horizontal blanking interval it pre-fetches the next visible line into a ping-pong line buffer, and interleaves fixed host write slots so that host writes are never starved during a fetch. It sits between the VGA timing generator (which supplies `line_start`/`line_num`/`pix_x`), the framebuffer RAM and the host bus.

## Interface
- `HWIDTH`, 640, visible pixels per line
- `VWIDTH`, 480, visible lines
- `HTOTAL`, 800, clocks per line
- `DW`, 16, pixel width (RGB565)
- `AW`, 19, framebuffer word address width
- `FETCH_BURST`, 8, fetch reads issued between two host slots
- `clk` in 1 pixel clock; the only clock
- `rst` in 1 asynchronous, active-high reset
- `line_start` in 1 single-cycle pulse: start of fetch for line `line_num`
- `line_num` in 10 line to fetch; sampled when `line_start`=1
- `pix_x` in 10 display pixel index
- `pix_data` out DW line-buffer pixel for `pix_x`
- `host_valid` in 1 host write request
- `host_ready` out 1 host write accepted when both are high
- `host_addr` in AW host write address
- `host_wdata` in DW host write data
- `mem_req` out 1 RAM access this cycle
- `mem_we` out 1 1=write, 0=read
- `mem_addr` out AW RAM address
- `mem_wdata` out DW RAM write data
- `mem_rdata` in DW RAM read data, valid exactly 1 cycle after a read
- `underrun` out 1 sticky: fetch not finished before the next `line_start`

## Operation
- FSM states:
  - IDLE: the host owns the RAM.
  - FETCH: a fetch read is issued every cycle.
  - SLOT: one host cycle.
- IDLE:
  - `host_ready`=1.
  - `mem_req`=`mem_we`=`host_valid`, with `mem_addr`/`mem_wdata` taken from the host inputs.
- IDLE to FETCH on `line_start` with `line_num`<VWIDTH.
  - `base` <= `line_num`*HWIDTH.
  - Index <= 0.
  - Burst counter <= 0.
- `line_start` with `line_num`>=VWIDTH:
  - No fetch; stay in IDLE.
  - The bank still toggles.
- FETCH:
  - `host_ready`=0, `mem_req`=1, `mem_we`=0, `mem_addr`=`base`+index.
  - Index and burst counter both increment.
  - When index reaches HWIDTH-1: issue that read, then go to IDLE.
  - Otherwise, when burst counter reaches FETCH_BURST-1: go to SLOT.
- SLOT:
  - `host_ready`=1, independent of `host_valid`.
  - A host write is performed if `host_valid`=1; otherwise the cycle is idle.
  - Always returns to FETCH; burst counter <= 0.
- Line-buffer writes:
  - Read data is written to the fill bank at the delayed index on the cycle after each read.
  - Two banks of HWIDTH×DW.
- On every `line_start`: `disp_bank` toggles, and the fill bank is `~disp_bank`.
- `pix_data` <= display bank[`pix_x`] each cycle (1-cycle latency). `pix_x`>=HWIDTH returns 0.
- `underrun`:
  - Set when `line_start` arrives with state ≠ IDLE.
  - The aborted fetch is abandoned and its in-flight read datum is discarded.
  - The new fetch starts normally.
  - Cleared only by `rst`.
- `line_start` in the same cycle as `host_valid` in IDLE: the host write is accepted that cycle; the first fetch read is issued next cycle.

## Timing
- Reset values:
  - State IDLE; `host_ready`=0 while `rst` is high.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `pix_data`=0, `underrun`=0, `disp_bank`=0.
  - Counters 0; `base`=0.
- `rst` asserted mid-fetch: immediate return to IDLE; no further RAM reads.
- `line_start` at cycle 0 (defaults):
  - Fetch reads at cycles 1..719.
  - 79 SLOT cycles, at cycles 9, 18, …, 711.
  - Last line-buffer write at cycle 720.
  - Margin of 80 cycles before the next `line_start` at cycle 800.
- Address arithmetic: `line_num`*HWIDTH+index, unsigned, AW bits. Maximum 307199, so no wrap.

## Structure
- Shared package `vga_pkg`:
  - Default timing constants.
  - FSM enum `fb_state_t` {IDLE, FETCH, SLOT}.
  - RGB565 colour constants.
- Sub-module `vga_line_buffer`:
  - Two-bank simple dual-port RAM: one write port (fill bank) and one registered read port (display bank).

## Test plan
- Host writes only, no `line_start` → every request accepted with `host_ready`=1. `mem_we`=1 with the addr/data echoed in the same cycle.
- `line_start` with `line_num`=3 at cycle 0 → first read `mem_addr`=1920 at cycle 1, SLOT at cycle 9, last read `mem_addr`=2559 at cycle 719. The next line displays the RAM contents 1920..2559 on `pix_data`.
- `host_valid` held high during a fetch → exactly one write per 9-cycle period (79 writes total); no fetch read is lost.
- `line_num`=500 → no `mem_req` reads and `host_ready` stays 1 for the whole line; `disp_bank` still toggles.
- Second `line_start` at cycle 400 → `underrun`=1 and the fetch restarts at the new `line_num`*640. `underrun` stays set until `rst`.
- `rst` pulsed at cycle 300 of a fetch → all outputs at their reset values immediately, state IDLE, `underrun`=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA framebuffer path.
package vga_pkg;

  // Default 640x480 timing and framebuffer geometry.
  localparam int DEF_HWIDTH      = 640;
  localparam int DEF_VWIDTH      = 480;
  localparam int DEF_HTOTAL      = 800;
  localparam int DEF_DW          = 16;
  localparam int DEF_AW          = 19;
  localparam int DEF_FETCH_BURST = 8;

  // Arbiter states:
  //   IDLE  : host owns the RAM
  //   FETCH : one line-fetch read per cycle
  //   SLOT  : one host cycle inserted between fetch bursts
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SLOT  = 2'd2
  } fb_state_t;

  // RGB565 reference colours.
  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_RED   = 16'hF800;
  localparam logic [15:0] RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;

endpackage

// File: rtl/vga_line_buffer.sv
// Ping-pong line buffer: two banks, one write port (fill bank) and one
// registered read port (display bank). Out-of-range reads return zero.
module vga_line_buffer #(
  parameter int DEPTH = 640,
  parameter int DW    = 16,
  parameter int IW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          wbank,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic          rbank,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2][DEPTH];

  // Storage array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wbank][waddr] <= wdata;
  end

  // Registered read; re low (pixel outside the visible line) yields zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[rbank][raddr];
    else         rdata <= '0;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: pre-fetches the next visible line into a
// ping-pong line buffer during blanking, interleaving host write slots.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int HWIDTH      = DEF_HWIDTH,
  parameter int VWIDTH      = DEF_VWIDTH,
  parameter int DW          = DEF_DW,
  parameter int AW          = DEF_AW,
  parameter int FETCH_BURST = DEF_FETCH_BURST
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          line_start,
  input  logic [9:0]    line_num,
  input  logic [9:0]    pix_x,
  output logic [DW-1:0] pix_data,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          underrun
);

  localparam int IW = $clog2(HWIDTH);
  localparam int BW = (FETCH_BURST > 1) ? $clog2(FETCH_BURST) : 1;
  localparam logic [9:0]    VLIM       = 10'(VWIDTH);
  localparam logic [9:0]    HLIM       = 10'(HWIDTH);
  localparam logic [IW-1:0] IDX_LAST   = IW'(HWIDTH - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(FETCH_BURST - 1);

  fb_state_t     state;
  logic [AW-1:0] base;
  logic [IW-1:0] idx;
  logic [BW-1:0] burst;
  logic          disp_bank;
  logic          rd_vld;
  logic [IW-1:0] rd_idx;

  // Fetch sequencer; a new line_start always wins, restarting or cancelling the fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      base  <= '0;
      idx   <= '0;
      burst <= '0;
    end else if (line_start) begin
      idx   <= '0;
      burst <= '0;
      if (line_num < VLIM) begin
        state <= FETCH;
        base  <= AW'(line_num) * AW'(HWIDTH);
      end else begin
        state <= IDLE;
      end
    end else begin
      case (state)
        FETCH: begin
          idx   <= idx + 1'b1;
          burst <= burst + 1'b1;
          if (idx == IDX_LAST)           state <= IDLE;
          else if (burst == BURST_LAST)  state <= SLOT;
        end
        SLOT: begin
          burst <= '0;
          state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-return tracking, bank swap and sticky underrun flag. A read issued
  // in the same cycle as line_start belongs to the abandoned fetch, so its
  // datum is dropped rather than landing in the freshly swapped fill bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld    <= 1'b0;
      rd_idx    <= '0;
      disp_bank <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      rd_vld <= (state == FETCH) && !line_start;
      rd_idx <= idx;
      if (line_start) begin
        disp_bank <= ~disp_bank;
        if (state != IDLE) underrun <= 1'b1;
      end
    end
  end

  // RAM port mux: fetch reads in FETCH, host pass-through in IDLE and SLOT.
  always_comb begin
    host_ready = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (!rst) begin
      case (state)
        FETCH: begin
          mem_req  = 1'b1;
          mem_addr = base + AW'(idx);
        end
        default: begin
          host_ready = 1'b1;
          mem_req    = host_valid;
          mem_we     = host_valid;
          mem_addr   = host_addr;
          mem_wdata  = host_wdata;
        end
      endcase
    end
  end

  vga_line_buffer #(
    .DEPTH (HWIDTH),
    .DW    (DW),
    .IW    (IW)
  ) u_line_buffer (
    .clk   (clk),
    .rst   (rst),
    .we    (rd_vld),
    .wbank (~disp_bank),
    .waddr (rd_idx),
    .wdata (mem_rdata),
    .re    (pix_x < HLIM),
    .rbank (disp_bank),
    .raddr (pix_x[IW-1:0]),
    .rdata (pix_data)
  );

endmodule
